// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial N-bit adder sequencing one decoder-based full-adder cell
// fa_decoder is the shared 1-bit cell; serial_add_ctrl feeds it LSB first and recirculates the carry.

module fa_decoder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  logic [7:0] minterm;

  always_comb begin
    minterm = '0;
    minterm[{A, B, Cin}] = 1'b1;
  end

  assign S    = minterm[1] | minterm[2] | minterm[4] | minterm[7];
  assign Cout = minterm[3] | minterm[5] | minterm[6] | minterm[7];
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_q;
  logic             carry, cout_q;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic             last_bit;
  logic [WIDTH-1:0] sum_sh_nxt;

  fa_decoder u_fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry),
    .S    (fa_s),
    .Cout (fa_c)
  );

  assign last_bit   = (cnt == CW'(WIDTH - 1));
  assign sum_sh_nxt = {fa_s, sum_sh[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Result registers are loaded only on the final RUN edge so they hold through IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            cnt    <= '0;
            sum_sh <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_sh_nxt;
          carry  <= fa_c;
          if (last_bit) begin
            sum_q  <= sum_sh_nxt;
            cout_q <= fa_c;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl (WIDTH = 8)

module tb_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;

  int n_cmp = 0;
  int n_err = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < budget) begin
      tick();
      cycles++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({busy, done, cout, sum} !== 11'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
    end
    reset = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      n_cmp++;
      if ({busy, done} !== 2'b10) begin
        n_err++;
        $display("FAIL basic_run_cycle%0d: got busy=%b done=%b, want 1 0", i, busy, done);
      end
      tick();
    end
    n_cmp++;
    if ({busy, done} !== 2'b01) begin
      n_err++;
      $display("FAIL basic_done_cycle9: got busy=%b done=%b, want 0 1", busy, done);
    end
    n_cmp++;
    if ({cout, sum} !== 9'h096) begin
      n_err++;
      $display("FAIL basic_sum: got cout=%b sum=%h, want cout=0 sum=96", cout, sum);
    end
    tick();
    n_cmp++;
    if ({busy, done, cout, sum} !== {2'b00, 9'h096}) begin
      n_err++;
      $display("FAIL basic_hold: got busy=%b done=%b cout=%b sum=%h, want 0 0 0 96", busy, done, cout, sum);
    end
  endtask

  task automatic test_carry();
    int cyc;
    bit seen;
    a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(20, cyc, seen);
    n_cmp++;
    if (!seen || cyc != 8 || {cout, sum} !== 9'h100) begin
      n_err++;
      $display("FAIL carry_ff_01: seen=%b cycles=%0d cout=%b sum=%h, want seen=1 cycles=8 cout=1 sum=00", seen, cyc, cout, sum);
    end
    tick();
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(20, cyc, seen);
    n_cmp++;
    if (!seen || {cout, sum} !== 9'h1FF) begin
      n_err++;
      $display("FAIL carry_ff_ff_1: seen=%b cout=%b sum=%h, want seen=1 cout=1 sum=ff", seen, cout, sum);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    int dones;
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    tick();
    dones = 0;
    a = 8'hAA;
    for (int i = 1; i <= 14; i++) begin
      start = (i <= 6);
      a = a + 8'h13;
      b = b ^ 8'h5C;
      cin = ~cin;
      if (done === 1'b1) begin
        dones++;
        n_cmp++;
        if ({cout, sum} !== 9'h030) begin
          n_err++;
          $display("FAIL ignore_sum: got cout=%b sum=%h, want cout=0 sum=30", cout, sum);
        end
      end
      tick();
    end
    n_cmp++;
    if (dones != 1) begin
      n_err++;
      $display("FAIL ignore_done_count: got %0d pulses, want 1", dones);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    int cyc;
    bit seen;
    a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL abort_precondition: got busy=%b, want 1", busy);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, cout, sum} !== 11'b0) begin
      n_err++;
      $display("FAIL abort_outputs: got busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
    end
    tick();
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL abort_no_done: got %0d active cycles, want 0", dones);
    end
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(20, cyc, seen);
    n_cmp++;
    if (!seen || {cout, sum} !== 9'h003) begin
      n_err++;
      $display("FAIL abort_recover: seen=%b cout=%b sum=%h, want seen=1 cout=0 sum=03", seen, cout, sum);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit seen;
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    wait_done(20, cyc, seen);
    n_cmp++;
    if (!seen || {cout, sum} !== 9'h010) begin
      n_err++;
      $display("FAIL b2b_first: seen=%b cout=%b sum=%h, want seen=1 cout=0 sum=10", seen, cout, sum);
    end
    for (int p = 0; p < 3; p++) begin
      int gap;
      int unstable;
      gap = 0;
      unstable = 0;
      seen = 1'b0;
      while (!seen && gap < 20) begin
        tick();
        gap++;
        if ({cout, sum} !== 9'h010) unstable++;
        if (done === 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (!seen || gap != 10 || unstable != 0) begin
        n_err++;
        $display("FAIL b2b_period%0d: seen=%b gap=%0d unstable=%0d, want seen=1 gap=10 unstable=0", p, seen, gap, unstable);
      end
    end
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_truth_table();
    int cyc;
    bit seen;
    logic [8:0] exp_v;
    for (int k = 0; k < 8; k++) begin
      a = {7'b0, k[2]};
      b = {7'b0, k[1]};
      cin = k[0];
      exp_v = {1'b0, 6'b0, 2'(k[2] + k[1] + k[0])};
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(20, cyc, seen);
      n_cmp++;
      if (!seen || {cout, sum} !== exp_v) begin
        n_err++;
        $display("FAIL fa_table_%0d: seen=%b cout=%b sum=%h, want cout=%b sum=%h", k, seen, cout, sum, exp_v[8], exp_v[7:0]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_truth_table();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial N-bit adder controller built around one instance of the team's decoder-based 1-bit full adder (fa_decoder: A, B, Cin, S, Cout, in that positional order). It latches two operands on a start request and feeds the single full-adder cell one bit per clock, LSB first, while carrying Cout back into Cin. It accumulates the sum and reports completion with a one-cycle done pulse. It is the sequencing layer that lets the combinational 1-bit cell serve multi-bit arithmetic.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request to begin an addition; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepted start edge
b  input  WIDTH  operand B; captured on the accepted start edge
cin  input  1  initial carry-in; captured on the accepted start edge
busy  output  1  high while in RUN
done  output  1  one-cycle pulse in DONE
sum  output  WIDTH  result; valid from DONE until the next accepted start
cout  output  1  final carry-out; valid with sum

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - busy = 0, done = 0, sum = 0, cout = 0.
  - Operand shift registers, carry register and bit counter cleared.
  - Assertion mid-RUN or in DONE aborts immediately; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - On a clk edge with start = 1: a_sh <= a, b_sh <= b, carry <= cin, cnt <= 0, sum_sh <= 0, state <= RUN.
  - sum and cout keep their previous values.
  - start = 0: remain in IDLE.
- RUN (busy = 1):
  - Full adder is driven combinationally with A = a_sh[0], B = b_sh[0], Cin = carry.
  - Each edge: a_sh and b_sh shift right by one; sum_sh shifts right with S entering at bit WIDTH-1; carry <= Cout; cnt <= cnt + 1.
  - When cnt == WIDTH-1 on an edge, the final bit is processed and state <= DONE. The shift completes, so sum_sh holds the full result LSB-aligned.
  - start is ignored.
- DONE (done = 1, busy = 0):
  - sum = sum_sh and cout = carry, both registered and stable.
  - Next edge: state <= IDLE.
  - start is ignored in DONE; it must be presented in IDLE.
- Latency:
  - start accepted at edge 0 → RUN during cycles 1..WIDTH → done high during cycle WIDTH+1.
  - Maximum throughput is one addition per WIDTH+2 cycles.
- Arithmetic: {cout, sum} = a + b + cin, with (WIDTH+1)-bit result and no truncation of carry.
- Counter: width $clog2(WIDTH), compared against WIDTH-1; no wrap occurs because the state leaves RUN at the terminal count.
- Output hold: sum and cout hold the last result through IDLE. They change only at the DONE transition of the next operation, or on reset.
- Operand isolation: changes on a, b and cin after acceptance have no effect on the in-flight operation.

Test Plan:
1. WIDTH = 8, reset, then start with a = 0x5A, b = 0x3C, cin = 0 → busy high for exactly 8 cycles; done pulses once 9 cycles after the start edge; sum = 0x96, cout = 0.
2. a = 0xFF, b = 0x01, cin = 0 → sum = 0x00, cout = 1. Then a = 0xFF, b = 0xFF, cin = 1 → sum = 0xFF, cout = 1 (full carry ripple through all bits).
3. During RUN of a = 0x10, b = 0x20, pulse start with a = 0xAA and change a/b every cycle → ignored; result sum = 0x30, cout = 0; exactly one done pulse.
4. Assert reset for 1 cycle at RUN cycle 4 → busy, done, sum and cout go to 0 immediately; no done pulse follows. A subsequent start with a = 0x01, b = 0x02 yields sum = 0x03 normally.
5. Hold start = 1 continuously with a = 0x0F, b = 0x01 → start is accepted in IDLE only, giving done pulses every 10 cycles; sum = 0x10 each time and stays stable between pulses.
6. Sweep all 8 combinations of a[0], b[0], cin with the upper bits zero (WIDTH = 8) → sum[1:0] and cout match the 1-bit full-adder truth table with carry landing in sum[1]; cout = 0.
